// File: rtl/grad_descent_engine.sv
// Finite-difference gradient descent engine driving one shared external evaluator.
module grad_descent_engine #(
  parameter int unsigned W       = 32,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned H_LOG2  = 1,
  parameter int unsigned LR_LOG2 = 1,
  parameter int unsigned ITER_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W-1:0]      x_init,
  input  logic [ITER_W-1:0] max_iter,
  input  logic [W-1:0]      eps,
  output logic              eval_req,
  output logic [W-1:0]      eval_x,
  input  logic              eval_ack,
  input  logic [2*W-1:0]    eval_y,
  input  logic              eval_ovf,
  output logic [W-1:0]      x_out,
  output logic [2*W-1:0]    value,
  output logic [2*W-1:0]    gradient,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              overflow
);

  localparam int unsigned W2 = 2 * W;
  localparam logic [W:0]    H_VAL  = (W+1)'(1) << (H_LOG2 + FRAC);
  localparam logic [W-1:0]  MAX_W  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_W  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W2-1:0] MAX_W2 = {1'b0, {(W2-1){1'b1}}};
  localparam logic [W2-1:0] MIN_W2 = {1'b1, {(W2-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, EVAL_A, EVAL_B, GRAD, UPDATE, DONE} state_t;

  state_t              state_q, state_d;
  logic [W2-1:0]       ya_q, ya_d, yb_q, yb_d;
  logic [W-1:0]        eps_q, eps_d;
  logic [ITER_W-1:0]   max_q, max_d;
  logic                eval_req_d, done_d, busy_d, conv_d, ovf_d;
  logic [W-1:0]        eval_x_d, x_d;
  logic [W2-1:0]       value_d, grad_d;
  logic [ITER_W-1:0]   iter_d;

  // Second evaluation point x - h, saturated to W bits
  logic [W:0]   xmh_full;
  logic         xmh_ovf;
  logic [W-1:0] xmh_sat;
  assign xmh_full = {x_out[W-1], x_out} - H_VAL;
  assign xmh_ovf  = xmh_full[W] ^ xmh_full[W-1];
  assign xmh_sat  = xmh_ovf ? (xmh_full[W] ? MIN_W : MAX_W) : xmh_full[W-1:0];

  // Gradient: saturated (yA - yB) divided by h
  logic [W2:0]   gdiff_full;
  logic          gdiff_ovf;
  logic [W2-1:0] gdiff_sat, grad_new;
  assign gdiff_full = {ya_q[W2-1], ya_q} - {yb_q[W2-1], yb_q};
  assign gdiff_ovf  = gdiff_full[W2] ^ gdiff_full[W2-1];
  assign gdiff_sat  = gdiff_ovf ? (gdiff_full[W2] ? MIN_W2 : MAX_W2) : gdiff_full[W2-1:0];
  assign grad_new   = W2'($signed(gdiff_sat) >>> H_LOG2);

  // Step = gradient * learning rate narrowed to W bits, then x - step
  logic [W2-1:0]  gsh;
  logic [W2-W:0]  gsh_top;
  logic           step_ovf;
  logic [W-1:0]   step, step_abs;
  logic [W:0]     xnew_full;
  logic           xnew_ovf;
  logic [W-1:0]   xnew_sat;
  assign gsh       = W2'($signed(gradient) >>> LR_LOG2);
  assign gsh_top   = gsh[W2-1:W-1];
  assign step_ovf  = ~((&gsh_top) | ~(|gsh_top));
  assign step      = step_ovf ? (gsh[W2-1] ? MIN_W : MAX_W) : gsh[W-1:0];
  assign step_abs  = step[W-1] ? (W'(0) - step) : step;
  assign xnew_full = {x_out[W-1], x_out} - {step[W-1], step};
  assign xnew_ovf  = xnew_full[W] ^ xnew_full[W-1];
  assign xnew_sat  = xnew_ovf ? (xnew_full[W] ? MIN_W : MAX_W) : xnew_full[W-1:0];

  // Next-state and next-register computation
  always_comb begin
    state_d    = state_q;
    ya_d       = ya_q;
    yb_d       = yb_q;
    eps_d      = eps_q;
    max_d      = max_q;
    eval_req_d = 1'b0;
    eval_x_d   = eval_x;
    x_d        = x_out;
    value_d    = value;
    grad_d     = gradient;
    iter_d     = iter_count;
    conv_d     = converged;
    ovf_d      = overflow;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d        = x_init;
          max_d      = (max_iter == '0) ? ITER_W'(1) : max_iter;
          eps_d      = eps;
          iter_d     = '0;
          conv_d     = 1'b0;
          ovf_d      = 1'b0;
          eval_req_d = 1'b1;
          eval_x_d   = x_init;
          state_d    = EVAL_A;
        end
      end
      EVAL_A: begin
        eval_req_d = 1'b1;
        if (eval_req && eval_ack) begin
          ya_d       = eval_y;
          ovf_d      = overflow | eval_ovf | xmh_ovf;
          eval_req_d = 1'b0;
          eval_x_d   = xmh_sat;
          state_d    = EVAL_B;
        end
      end
      EVAL_B: begin
        eval_req_d = 1'b1;
        if (eval_req && eval_ack) begin
          yb_d       = eval_y;
          ovf_d      = overflow | eval_ovf;
          eval_req_d = 1'b0;
          state_d    = GRAD;
        end
      end
      GRAD: begin
        grad_d  = grad_new;
        value_d = ya_q;
        ovf_d   = overflow | gdiff_ovf;
        state_d = UPDATE;
      end
      UPDATE: begin
        x_d    = xnew_sat;
        iter_d = iter_count + ITER_W'(1);
        ovf_d  = overflow | step_ovf | xnew_ovf;
        if (step_abs <= eps_q) begin
          conv_d  = 1'b1;
          state_d = DONE;
        end else if (ovf_d || (iter_d == max_q)) begin
          state_d = DONE;
        end else begin
          eval_req_d = 1'b1;
          eval_x_d   = xnew_sat;
          state_d    = EVAL_A;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ya_q       <= '0;
      yb_q       <= '0;
      eps_q      <= '0;
      max_q      <= '0;
      eval_req   <= 1'b0;
      eval_x     <= '0;
      x_out      <= '0;
      value      <= '0;
      gradient   <= '0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ya_q       <= ya_d;
      yb_q       <= yb_d;
      eps_q      <= eps_d;
      max_q      <= max_d;
      eval_req   <= eval_req_d;
      eval_x     <= eval_x_d;
      x_out      <= x_d;
      value      <= value_d;
      gradient   <= grad_d;
      iter_count <= iter_d;
      busy       <= busy_d;
      done       <= done_d;
      converged  <= conv_d;
      overflow   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_grad_descent_engine.sv
// Directed bench for grad_descent_engine with an f(x)=x^2 evaluator model.
module tb_grad_descent_engine;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] x_init, eps;
  logic [7:0]  max_iter;
  logic        eval_req, eval_ack, eval_ovf;
  logic [31:0] eval_x;
  logic [63:0] eval_y;
  logic [31:0] x_out;
  logic [63:0] value, gradient;
  logic [7:0]  iter_count;
  logic        busy, done, converged, overflow;

  int n_cmp = 0;
  int n_err = 0;

  // Evaluator model controls
  int          ev_random    = 0;
  int          ev_ack_limit = -1;
  int          ev_ovf_once  = 0;
  int          ev_force_ack = 0;
  int          stable_err   = 0;
  logic [31:0] req_log[$];

  grad_descent_engine dut (
    .clk(clk), .rst(rst), .start(start), .x_init(x_init), .max_iter(max_iter), .eps(eps),
    .eval_req(eval_req), .eval_x(eval_x), .eval_ack(eval_ack), .eval_y(eval_y), .eval_ovf(eval_ovf),
    .x_out(x_out), .value(value), .gradient(gradient), .iter_count(iter_count),
    .busy(busy), .done(done), .converged(converged), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sq(input logic [31:0] x);
    logic signed [63:0] xs, p;
    xs = {{32{x[31]}}, x};
    p  = xs * xs;
    return 64'(p >>> 8);
  endfunction

  // Evaluator: one ack per request after 0 (or random 0..7) wait cycles
  initial begin
    int          dly;
    logic        have_req;
    logic [31:0] held_x;
    eval_ack = 1'b0; eval_y = '0; eval_ovf = 1'b0;
    have_req = 1'b0; dly = 0; held_x = '0;
    forever begin
      @(posedge clk); #1;
      eval_ack = 1'b0;
      eval_ovf = 1'b0;
      if (ev_force_ack != 0) begin
        eval_ack = 1'b1;
        eval_y   = 64'h1234;
        ev_force_ack = 0;
      end else if (eval_req) begin
        if (!have_req) begin
          have_req = 1'b1;
          held_x   = eval_x;
          dly      = (ev_random != 0) ? int'($urandom_range(0, 7)) : 0;
          req_log.push_back(eval_x);
        end else if (eval_x !== held_x) begin
          stable_err++;
        end
        if (dly == 0 && ev_ack_limit != 0) begin
          eval_ack = 1'b1;
          eval_y   = sq(eval_x);
          eval_ovf = (ev_ovf_once != 0);
          ev_ovf_once = 0;
          have_req = 1'b0;
          if (ev_ack_limit > 0) ev_ack_limit--;
        end else if (dly > 0) begin
          dly--;
        end
      end else begin
        have_req = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [31:0] x0, input logic [7:0] mi, input logic [31:0] e);
    req_log.delete();
    x_init = x0; max_iter = mi; eps = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = k;
        break;
      end
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic saw_done;
    rst = 1'b1; start = 1'b0; x_init = '0; max_iter = '0; eps = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_eval_req", 64'(eval_req), 64'd0);
    chk("rst_outs", {x_out, 8'(iter_count), 4'(0), done, converged, overflow, 1'b0}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic run, zero-wait evaluator: 2 iterations x 5 cycles
    go(32'h0000_0A00, 8'd8, 32'd0);
    chk("r1_busy", 64'(busy), 64'd1);
    chk("r1_req_a", 64'(eval_req), 64'd1);
    wait_done(cyc);
    chk("r1_latency", 64'(cyc), 64'd10);
    chk("r1_x_out", 64'(x_out), 64'h100);
    chk("r1_value", value, 64'h100);
    chk("r1_gradient", gradient, 64'h0);
    chk("r1_iter", 64'(iter_count), 64'd2);
    chk("r1_conv", 64'(converged), 64'd1);
    chk("r1_ovf", 64'(overflow), 64'd0);
    chk("r1_nreq", 64'(req_log.size()), 64'd4);
    chk("r1_xb1", 64'(req_log[1]), 64'h800);
    chk("r1_xa2", 64'(req_log[2]), 64'h100);
    chk("r1_xb2", 64'(req_log[3]), 64'hFFFF_FF00);
    @(posedge clk); #1;
    chk("r1_done_pulse", 64'(done), 64'd0);
    chk("r1_idle", 64'(busy), 64'd0);
    chk("r1_hold_x", 64'(x_out), 64'h100);

    // Same run with random evaluator latency
    ev_random = 1; stable_err = 0;
    go(32'h0000_0A00, 8'd8, 32'd0);
    wait_done(cyc);
    chk("r2_x_out", 64'(x_out), 64'h100);
    chk("r2_iter", 64'(iter_count), 64'd2);
    chk("r2_conv", 64'(converged), 64'd1);
    chk("r2_value", value, 64'h100);
    chk("r2_stable", 64'(stable_err), 64'd0);
    ev_random = 0;
    @(posedge clk); #1;

    // Iteration limit of one: grad=(0x6400-0x4000)/2, step=grad/2=0x900
    go(32'h0000_0A00, 8'd1, 32'd0);
    wait_done(cyc);
    chk("r3_latency", 64'(cyc), 64'd5);
    chk("r3_iter", 64'(iter_count), 64'd1);
    chk("r3_conv", 64'(converged), 64'd0);
    chk("r3_x_out", 64'(x_out), 64'h100);
    chk("r3_value", value, 64'h6400);
    chk("r3_gradient", gradient, 64'h1200);
    @(posedge clk); #1;

    // max_iter=0 behaves as 1
    go(32'h0000_0A00, 8'd0, 32'd0);
    wait_done(cyc);
    chk("r4_iter", 64'(iter_count), 64'd1);
    chk("r4_x_out", 64'(x_out), 64'h100);
    @(posedge clk); #1;

    // eps above first step: converges after one iteration
    go(32'h0000_0A00, 8'd8, 32'h0000_0900);
    wait_done(cyc);
    chk("r5_conv", 64'(converged), 64'd1);
    chk("r5_iter", 64'(iter_count), 64'd1);
    @(posedge clk); #1;

    // Negative saturation of x - h
    go(32'h8000_0100, 8'd8, 32'd0);
    wait_done(cyc);
    chk("r6_ovf", 64'(overflow), 64'd1);
    chk("r6_conv", 64'(converged), 64'd0);
    chk("r6_iter", 64'(iter_count), 64'd1);
    chk("r6_xb_clip", 64'(req_log[1]), 64'h8000_0000);
    @(posedge clk); #1;

    // start during busy and in the done cycle are ignored
    go(32'h0000_0A00, 8'd8, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    x_init = 32'h0000_4000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    chk("r7_x_out", 64'(x_out), 64'h100);
    chk("r7_iter", 64'(iter_count), 64'd2);
    chk("r7_ovf_clear", 64'(overflow), 64'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("r7_start_in_done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("r7_still_idle", 64'(busy), 64'd0);

    // Evaluator overflow flagged on first ack
    ev_ovf_once = 1;
    go(32'h0000_0A00, 8'd8, 32'd0);
    wait_done(cyc);
    chk("r8_ovf", 64'(overflow), 64'd1);
    chk("r8_iter", 64'(iter_count), 64'd1);
    chk("r8_conv", 64'(converged), 64'd0);
    @(posedge clk); #1;

    // Reset while waiting in EVAL_B, then a stray ack
    ev_ack_limit = 1;
    go(32'h0000_0A00, 8'd8, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("r9_in_b_req", 64'(eval_req), 64'd1);
    chk("r9_in_b_x", 64'(eval_x), 64'h800);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("r9_busy", 64'(busy), 64'd0);
    chk("r9_req", 64'(eval_req), 64'd0);
    chk("r9_outs", {x_out, 8'(iter_count), 4'(0), done, converged, overflow, 1'b0}, 64'd0);
    chk("r9_value", value | gradient, 64'd0);
    ev_ack_limit = -1;
    ev_force_ack = 1;
    saw_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done || busy || eval_req) saw_done = 1'b1;
    end
    chk("r9_ignored_ack", 64'(saw_done), 64'd0);

    // Fresh run after reset
    go(32'h0000_0A00, 8'd8, 32'd0);
    wait_done(cyc);
    chk("r10_x_out", 64'(x_out), 64'h100);
    chk("r10_iter", 64'(iter_count), 64'd2);
    chk("r10_conv", 64'(converged), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
